// File: rtl/text_console_ctrl.sv
// Character-cell text console controller: writes printable codes at the cursor,
// handles LF/CR/BS/FF, and scrolls the screen memory up one row when the cursor runs off the bottom.
module text_console_ctrl #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        mem_wr,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic [4:0]  cursor_row,
    output logic [5:0]  cursor_col,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUT     = 3'd1,
        S_CLEAR   = 3'd2,
        S_SCR_RD  = 3'd3,
        S_SCR_WR  = 3'd4,
        S_SCR_CLR = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_CHAR = 3'd0,
        OP_BS   = 3'd1,
        OP_LF   = 3'd2,
        OP_CR   = 3'd3,
        OP_NOP  = 3'd4
    } op_t;

    localparam logic [10:0] COLS_A     = 11'(COLS);
    localparam logic [10:0] LAST_ADDR  = 11'(COLS * ROWS - 1);
    localparam logic [10:0] COPY_BASE  = 11'(COLS * (ROWS - 1));
    localparam logic [10:0] COPY_LAST  = 11'(COLS * (ROWS - 1) - 1);
    localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
    // A one-row screen has nothing to copy, so scrolling reduces to clearing the row.
    localparam state_t      SCROLL_ENTRY = (ROWS > 1) ? S_SCR_RD : S_SCR_CLR;

    state_t      state_r;
    state_t      state_s;
    op_t         op_r;
    op_t         op_s;
    logic        is_ff_s;
    logic        scroll_s;
    logic [10:0] cnt_r;
    logic [10:0] row_base_s;
    logic [10:0] put_addr_s;
    logic [7:0]  data_r;
    logic [7:0]  latch_r;
    logic [4:0]  row_r;
    logic [5:0]  col_r;
    logic        mem_wr_s;
    logic [10:0] mem_addr_s;
    logic [7:0]  mem_din_s;

    // Classify the incoming code; BS at column 0 degenerates to a no-op.
    always_comb begin
        op_s    = OP_NOP;
        is_ff_s = 1'b0;
        if ((char_in >= 8'h20) && (char_in <= 8'h7E)) begin
            op_s = OP_CHAR;
        end else begin
            case (char_in)
                8'h0A:   op_s = OP_LF;
                8'h0D:   op_s = OP_CR;
                8'h08:   op_s = (col_r != 6'd0) ? OP_BS : OP_NOP;
                8'h0C:   is_ff_s = 1'b1;
                default: op_s = OP_NOP;
            endcase
        end
    end

    // Target cell address for a write at (or, for BS, just left of) the cursor.
    always_comb begin
        row_base_s = 11'(row_r) * COLS_A;
        if (op_s == OP_BS) begin
            put_addr_s = row_base_s + 11'(col_r) - 11'd1;
        end else begin
            put_addr_s = row_base_s + 11'(col_r);
        end
    end

    assign scroll_s = ((op_r == OP_CHAR) && (col_r == LAST_COL) && (row_r == LAST_ROW)) ||
                      ((op_r == OP_LF) && (row_r == LAST_ROW));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (char_valid) begin
                    state_s = is_ff_s ? S_CLEAR : S_PUT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PUT:     state_s = scroll_s ? SCROLL_ENTRY : S_IDLE;
            S_CLEAR:   state_s = (cnt_r == LAST_ADDR) ? S_IDLE : S_CLEAR;
            S_SCR_RD:  state_s = S_SCR_WR;
            S_SCR_WR:  state_s = (cnt_r == COPY_LAST) ? S_SCR_CLR : S_SCR_RD;
            S_SCR_CLR: state_s = (cnt_r == LAST_ADDR) ? S_IDLE : S_SCR_CLR;
            default:   state_s = S_IDLE;
        endcase
    end

    // Datapath: operation capture, address counter, read latch and cursor.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_r    <= OP_NOP;
            cnt_r   <= 11'd0;
            data_r  <= 8'h00;
            latch_r <= 8'h00;
            row_r   <= 5'd0;
            col_r   <= 6'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (char_valid) begin
                        op_r   <= op_s;
                        data_r <= (op_s == OP_BS) ? BLANK : char_in;
                        cnt_r  <= is_ff_s ? 11'd0 : put_addr_s;
                    end
                end
                S_PUT: begin
                    if (scroll_s) begin
                        cnt_r <= 11'd0;
                    end
                    case (op_r)
                        OP_CHAR: begin
                            if (col_r != LAST_COL) begin
                                col_r <= col_r + 6'd1;
                            end else begin
                                col_r <= 6'd0;
                                if (row_r != LAST_ROW) begin
                                    row_r <= row_r + 5'd1;
                                end
                            end
                        end
                        OP_LF: begin
                            col_r <= 6'd0;
                            if (row_r != LAST_ROW) begin
                                row_r <= row_r + 5'd1;
                            end
                        end
                        OP_CR:   col_r <= 6'd0;
                        OP_BS:   col_r <= col_r - 6'd1;
                        default: ;
                    endcase
                end
                S_CLEAR: begin
                    if (cnt_r == LAST_ADDR) begin
                        cnt_r <= 11'd0;
                        row_r <= 5'd0;
                        col_r <= 6'd0;
                    end else begin
                        cnt_r <= cnt_r + 11'd1;
                    end
                end
                S_SCR_RD: latch_r <= mem_dout;
                S_SCR_WR: begin
                    if (cnt_r == COPY_LAST) begin
                        cnt_r <= COPY_BASE;
                    end else begin
                        cnt_r <= cnt_r + 11'd1;
                    end
                end
                S_SCR_CLR: begin
                    if (cnt_r == LAST_ADDR) begin
                        cnt_r <= 11'd0;
                    end else begin
                        cnt_r <= cnt_r + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory port outputs decoded from the current state.
    always_comb begin
        mem_wr_s   = 1'b0;
        mem_addr_s = 11'd0;
        mem_din_s  = 8'h00;
        case (state_r)
            S_PUT: begin
                mem_wr_s   = (op_r == OP_CHAR) || (op_r == OP_BS);
                mem_addr_s = cnt_r;
                mem_din_s  = data_r;
            end
            S_CLEAR, S_SCR_CLR: begin
                mem_wr_s   = 1'b1;
                mem_addr_s = cnt_r;
                mem_din_s  = BLANK;
            end
            S_SCR_RD: begin
                mem_wr_s   = 1'b0;
                mem_addr_s = cnt_r + COLS_A;
                mem_din_s  = 8'h00;
            end
            S_SCR_WR: begin
                mem_wr_s   = 1'b1;
                mem_addr_s = cnt_r;
                mem_din_s  = latch_r;
            end
            default: begin
                mem_wr_s   = 1'b0;
                mem_addr_s = 11'd0;
                mem_din_s  = 8'h00;
            end
        endcase
    end

    // Reset suppresses the write of the cycle it arrives in, so an abort leaves no extra cell written.
    assign mem_wr     = mem_wr_s & ~reset;
    assign mem_addr   = mem_addr_s;
    assign mem_din    = mem_din_s;
    assign char_ready = (state_r == S_IDLE) && !reset;
    assign busy       = (state_r != S_IDLE);
    assign cursor_row = row_r;
    assign cursor_col = col_r;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: a behavioural screen memory plus a
// scoreboard of expected writes that every observed mem_wr cycle is checked against.
module tb_text_console_ctrl;

    logic        clock;
    logic        reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        mem_wr;
    logic [10:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [4:0]  cursor_row;
    logic [5:0]  cursor_col;
    logic        busy;

    logic [7:0]  mem [0:1199];
    logic [7:0]  model [0:1199];
    logic [18:0] exp_q [$];
    int          n_checks;
    int          n_pass;

    text_console_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_dout = (mem_addr < 11'd1200) ? mem[mem_addr] : 8'h00;

    always @(posedge clock) begin
        if (mem_wr === 1'b1 && mem_addr < 11'd1200) mem[mem_addr] = mem_din;
    end

    // Scoreboard: every write cycle must match the oldest expected write.
    always @(negedge clock) begin
        logic [18:0] e;
        if (mem_wr === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr %0d din %02h, required no write", mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_din} !== e)
                    $display("FAIL write: got addr %0d din %02h, required addr %0d din %02h",
                             mem_addr, mem_din, e[18:8], e[7:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        exp_q.push_back({11'(a), d});
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 5000 && busy; k++) begin
            @(posedge clock); #1;
        end
        n_checks++;
        if (busy) $display("FAIL idle_timeout: busy still %0b after %0d cycles, required 0", busy, k);
        else n_pass++;
    endtask

    task automatic send_char(input logic [7:0] c);
        logic acc;
        acc = 1'b0;
        char_in    = c;
        char_valid = 1'b1;
        for (int k = 0; k < 5000 && !acc; k++) begin
            acc = char_ready;
            @(posedge clock); #1;
        end
        char_valid = 1'b0;
        n_checks++;
        if (!acc) $display("FAIL accept_timeout: char %02h never accepted, required acceptance", c);
        else n_pass++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic check_queue_empty(input string name);
        @(posedge clock); #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_missing_writes: %0d pending, required 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({char_ready, busy, mem_wr} !== 3'b000) $display("FAIL reset_ctrl: got ready/busy/wr %03b, required 000", {char_ready, busy, mem_wr});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_din} !== 19'd0) $display("FAIL reset_mem_port: got addr %0d din %02h, required 0 0", mem_addr, mem_din);
        else n_pass++;
        n_checks++;
        if ({cursor_row, cursor_col} !== 11'd0) $display("FAIL reset_cursor: got %0d,%0d, required 0,0", cursor_row, cursor_col);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (char_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", char_ready);
        else n_pass++;
    endtask

    task automatic test_put_a();
        do_reset();
        push_wr(0, 8'h41);
        send_char(8'h41);
        n_checks++;
        if ({busy, char_ready} !== 2'b10) $display("FAIL put_handshake: got busy/ready %02b, required 10", {busy, char_ready});
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (char_ready !== 1'b1) $display("FAIL put_ready_back: got %0b, required 1", char_ready);
        else n_pass++;
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd0, 6'd1}) $display("FAIL put_cursor: got %0d,%0d, required 0,1", cursor_row, cursor_col);
        else n_pass++;
        check_queue_empty("put");
    endtask

    task automatic test_row_fill();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push_wr(i, 8'h42);
            send_char(8'h42);
        end
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd1, 6'd0}) $display("FAIL fill_cursor: got %0d,%0d, required 1,0", cursor_row, cursor_col);
        else n_pass++;
        send_char(8'h0A);
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd2, 6'd0}) $display("FAIL lf_cursor: got %0d,%0d, required 2,0", cursor_row, cursor_col);
        else n_pass++;
        check_queue_empty("fill");
    endtask

    task automatic test_form_feed();
        int n_busy;
        int bad;
        for (int i = 0; i < 1200; i++) push_wr(i, 8'h20);
        send_char(8'h0C);
        n_busy = 0;
        for (int k = 0; k < 5000 && busy; k++) begin
            n_busy++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (n_busy != 1200) $display("FAIL ff_busy_cycles: got %0d, required 1200", n_busy);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 1200; i++) if (mem[i] !== 8'h20) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL ff_contents: %0d cells not blank, required 0", bad);
        else n_pass++;
        n_checks++;
        if ({cursor_row, cursor_col} !== 11'd0) $display("FAIL ff_cursor: got %0d,%0d, required 0,0", cursor_row, cursor_col);
        else n_pass++;
        send_char(8'h08);
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== 11'd0) $display("FAIL bs_col0_cursor: got %0d,%0d, required 0,0", cursor_row, cursor_col);
        else n_pass++;
        check_queue_empty("ff");
    endtask

    task automatic test_backspace_other();
        do_reset();
        for (int i = 0; i < 3; i++) send_char(8'h0A);
        for (int i = 0; i < 5; i++) begin
            push_wr(120 + i, 8'h63);
            send_char(8'h63);
        end
        wait_idle();
        push_wr(124, 8'h20);
        send_char(8'h08);
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd3, 6'd4}) $display("FAIL bs_cursor: got %0d,%0d, required 3,4", cursor_row, cursor_col);
        else n_pass++;
        send_char(8'h07);
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd3, 6'd4}) $display("FAIL other_cursor: got %0d,%0d, required 3,4", cursor_row, cursor_col);
        else n_pass++;
        send_char(8'h0D);
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd3, 6'd0}) $display("FAIL cr_cursor: got %0d,%0d, required 3,0", cursor_row, cursor_col);
        else n_pass++;
        check_queue_empty("bs");
    endtask

    task automatic test_scroll();
        int n_busy;
        int bad;
        for (int i = 0; i < 1200; i++) push_wr(i, 8'h20);
        send_char(8'h0C);
        wait_idle();
        for (int i = 0; i < 29; i++) send_char(8'h0A);
        for (int i = 0; i < 39; i++) begin
            push_wr(1160 + i, 8'h71);
            send_char(8'h71);
        end
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd29, 6'd39}) $display("FAIL pre_scroll_cursor: got %0d,%0d, required 29,39", cursor_row, cursor_col);
        else n_pass++;
        for (int i = 0; i < 1200; i++) begin
            mem[i]   = 8'(i);
            model[i] = 8'(i);
        end
        model[1199] = 8'h5A;
        push_wr(1199, 8'h5A);
        for (int d = 0; d < 1160; d++) push_wr(d, model[d + 40]);
        for (int d = 1160; d < 1200; d++) push_wr(d, 8'h20);
        for (int d = 0; d < 1160; d++) model[d] = model[d + 40];
        for (int d = 1160; d < 1200; d++) model[d] = 8'h20;
        send_char(8'h5A);
        // One PUT cycle followed by the 2360-cycle scroll.
        n_busy = 0;
        for (int k = 0; k < 5000 && busy; k++) begin
            n_busy++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (n_busy != 2361) $display("FAIL scroll_busy_cycles: got %0d, required 2361", n_busy);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 1200; i++) if (mem[i] !== model[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL scroll_contents: %0d cells wrong, required 0", bad);
        else n_pass++;
        n_checks++;
        if (mem[1159] !== 8'h5A) $display("FAIL scroll_moved_char: got %02h, required 5a", mem[1159]);
        else n_pass++;
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd29, 6'd0}) $display("FAIL scroll_cursor: got %0d,%0d, required 29,0", cursor_row, cursor_col);
        else n_pass++;
        check_queue_empty("scroll");
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [0:4];
        logic acc;
        int i;
        do_reset();
        seq[0] = 8'h61; seq[1] = 8'h62; seq[2] = 8'h63; seq[3] = 8'h64; seq[4] = 8'h65;
        for (int j = 0; j < 5; j++) push_wr(j, seq[j]);
        i = 0;
        char_in    = seq[0];
        char_valid = 1'b1;
        for (int k = 0; k < 200 && i < 5; k++) begin
            acc = char_ready;
            @(posedge clock); #1;
            if (acc) begin
                i++;
                if (i < 5) char_in = seq[i];
                else char_valid = 1'b0;
            end
        end
        char_valid = 1'b0;
        wait_idle();
        n_checks++;
        if ({cursor_row, cursor_col} !== {5'd0, 6'd5}) $display("FAIL b2b_cursor: got %0d,%0d, required 0,5", cursor_row, cursor_col);
        else n_pass++;
        check_queue_empty("b2b");
    endtask

    task automatic test_reset_abort();
        int bad;
        wait_idle();
        for (int i = 0; i < 1200; i++) mem[i] = 8'hA5;
        for (int i = 0; i < 100; i++) push_wr(i, 8'h20);
        send_char(8'h0C);
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({char_ready, busy} !== 2'b10) $display("FAIL abort_ready: got ready/busy %02b, required 10", {char_ready, busy});
        else n_pass++;
        n_checks++;
        if ({cursor_row, cursor_col} !== 11'd0) $display("FAIL abort_cursor: got %0d,%0d, required 0,0", cursor_row, cursor_col);
        else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        bad = 0;
        for (int i = 0; i < 1200; i++) if (mem[i] !== ((i < 100) ? 8'h20 : 8'hA5)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL abort_contents: %0d cells wrong, required 0", bad);
        else n_pass++;
        check_queue_empty("abort");
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        for (int i = 0; i < 1200; i++) mem[i] = 8'h00;
        test_reset();
        test_put_a();
        test_row_fill();
        test_form_feed();
        test_backspace_other();
        test_scroll();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
